// File: rtl/s_term_pkg.sv
// s_term_pkg: shared types and constants for the south-edge terminal tile.
//   mode_t       2-bit per-group loopback mode (PASS, REG, ZERO, ONE)
//   CFG_W        width of the tile configuration field
//   MODE_W       width of one group's mode field
//   CO_IDX       cfg bit that drives the carry terminator
//   G1..G4       group index; group k uses cfg[k*MODE_W +: MODE_W]
package s_term_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    REG  = 2'b01,
    ZERO = 2'b10,
    ONE  = 2'b11
  } mode_t;

  localparam int unsigned CFG_W  = 9;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CO_IDX = 8;

  localparam int unsigned G1  = 0;
  localparam int unsigned G2M = 1;
  localparam int unsigned G2E = 2;
  localparam int unsigned G4  = 3;

endpackage

// File: rtl/s_term_wire_group.sv
// s_term_wire_group: loopback for one wire group of the south terminal.
// Macro S_TERM_REG_EN: when defined, a pipeline register samples din on
// every clock edge and mode REG selects it; when undefined no flops are
// built and REG behaves as PASS.
// Ports:
//   clk    in  1      fabric clock (rising edge)
//   rst_n  in  1      asynchronous active-low reset
//   mode   in  mode_t loopback mode for this group
//   din    in  WIDTH  southbound wires
//   dout   out WIDTH  northbound wires
module s_term_wire_group
  import s_term_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

`ifdef S_TERM_REG_EN
  // Sampled regardless of mode so entering REG never exposes stale data.
  logic [WIDTH-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= din;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk ^ rst_n;
`endif

  always_comb begin
    dout = din;
    case (mode)
      PASS: dout = din;
`ifdef S_TERM_REG_EN
      REG:  dout = pipe_q;
`else
      REG:  dout = din;
`endif
      ZERO: dout = '0;
      ONE:  dout = '1;
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/s_term_param.sv
// s_term_param: parametrised south-edge terminal tile for the bottom row.
// Loops each southbound group back north under a frame-configured mode,
// ties off the carry chain and forwards frame configuration signals.
// Macro S_TERM_REG_EN enables the per-group one-cycle REG mode.
// Ports:
//   UserCLK        in  1                fabric clock
//   resetn         in  1                asynchronous active-low reset
//   S1END/N1BEG    in/out W1            single wires (group G1)
//   S2MID/N2BEG    in/out W2            double midpoints (group G2M)
//   S2END/N2BEGb   in/out W2            double ends (group G2E)
//   S4END/N4BEG    in/out W4            quad wires (group G4)
//   Co             out 1                carry terminator = cfg[8]
//   FrameData      in  FrameBitsPerRow  configuration data row
//   FrameStrobe    in  MaxFramesPerCol  frame strobes
//   FrameData_O    out FrameBitsPerRow  copy of FrameData
//   FrameStrobe_O  out MaxFramesPerCol  copy of FrameStrobe
module s_term_param
  import s_term_pkg::*;
#(
  parameter int unsigned W1              = 4,
  parameter int unsigned W2              = 8,
  parameter int unsigned W4              = 16,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned CFG_FRAME       = 0,
  parameter int unsigned CFG_BIT         = 0
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [W1-1:0]              S1END,
  input  logic [W2-1:0]              S2MID,
  input  logic [W2-1:0]              S2END,
  input  logic [W4-1:0]              S4END,
  output logic [W1-1:0]              N1BEG,
  output logic [W2-1:0]              N2BEG,
  output logic [W2-1:0]              N2BEGb,
  output logic [W4-1:0]              N4BEG,
  output logic                       Co,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

  logic [CFG_W-1:0] cfg;
  logic             str_q;
  logic             strobe;

  assign strobe = FrameStrobe[CFG_FRAME];

  // str_q resets high: a strobe already asserted across reset release must
  // first be sampled low before it can produce a load edge.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      cfg   <= '0;
      str_q <= 1'b1;
    end else begin
      str_q <= strobe;
      if (strobe && !str_q) begin
        cfg <= FrameData[CFG_BIT +: CFG_W];
      end
    end
  end

  assign Co = cfg[CO_IDX];

  s_term_wire_group #(.WIDTH(W1)) u_g1 (
    .clk   (UserCLK),
    .rst_n (resetn),
    .mode  (mode_t'(cfg[G1*MODE_W +: MODE_W])),
    .din   (S1END),
    .dout  (N1BEG)
  );

  s_term_wire_group #(.WIDTH(W2)) u_g2m (
    .clk   (UserCLK),
    .rst_n (resetn),
    .mode  (mode_t'(cfg[G2M*MODE_W +: MODE_W])),
    .din   (S2MID),
    .dout  (N2BEG)
  );

  s_term_wire_group #(.WIDTH(W2)) u_g2e (
    .clk   (UserCLK),
    .rst_n (resetn),
    .mode  (mode_t'(cfg[G2E*MODE_W +: MODE_W])),
    .din   (S2END),
    .dout  (N2BEGb)
  );

  s_term_wire_group #(.WIDTH(W4)) u_g4 (
    .clk   (UserCLK),
    .rst_n (resetn),
    .mode  (mode_t'(cfg[G4*MODE_W +: MODE_W])),
    .din   (S4END),
    .dout  (N4BEG)
  );

  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;

endmodule

// File: tb/tb_s_term_param.sv
// tb_s_term_param: directed self-checking bench for s_term_param.
// Expectations for REG mode follow S_TERM_REG_EN.
module tb_s_term_param;

  logic        UserCLK;
  logic        resetn;
  logic [3:0]  S1END;
  logic [7:0]  S2MID;
  logic [7:0]  S2END;
  logic [15:0] S4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG;
  logic [7:0]  N2BEGb;
  logic [15:0] N4BEG;
  logic        Co;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [31:0] FrameData_O;
  logic [19:0] FrameStrobe_O;

  int checks;
  int failures;

  s_term_param #(
    .W1(4), .W2(8), .W4(16),
    .MaxFramesPerCol(20), .FrameBitsPerRow(32),
    .CFG_FRAME(0), .CFG_BIT(0)
  ) dut (
    .UserCLK       (UserCLK),
    .resetn        (resetn),
    .S1END         (S1END),
    .S2MID         (S2MID),
    .S2END         (S2END),
    .S4END         (S4END),
    .N1BEG         (N1BEG),
    .N2BEG         (N2BEG),
    .N2BEGb        (N2BEGb),
    .N4BEG         (N4BEG),
    .Co            (Co),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .FrameData_O   (FrameData_O),
    .FrameStrobe_O (FrameStrobe_O)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge UserCLK);
    #1;
  endtask

  // Strobe low for one edge, then one rising-strobe edge loading d.
  task automatic load(input logic [8:0] d);
    FrameStrobe = '0;
    tick();
    FrameData   = {23'd0, d};
    FrameStrobe = 20'd1;
    tick();
    FrameStrobe = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    S1END = '0; S2MID = '0; S2END = '0; S4END = '0;
    FrameData = '0; FrameStrobe = '0;

    // Reset: combinational pass, Co low
    #2;
    S1END = 4'hA; S4END = 16'h1234;
    #1;
    check("rst_n1", 32'(N1BEG), 32'h0000000A);
    check("rst_n4", 32'(N4BEG), 32'h00001234);
    check("rst_co", 32'(Co), 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // PASS after reset
    S1END = 4'h5; S2MID = 8'h3C; S2END = 8'hC3; S4END = 16'hBEEF;
    #1;
    check("pass_n1", 32'(N1BEG), 32'h5);
    check("pass_n2", 32'(N2BEG), 32'h3C);
    check("pass_n2b", 32'(N2BEGb), 32'hC3);
    check("pass_n4", 32'(N4BEG), 32'hBEEF);
    check("pass_co", 32'(Co), 32'h0);

    // All REG, Co=1; pipes hold the values sampled at the load edge
    load(9'h155);
    check("reg_co", 32'(Co), 32'h1);
    S1END = 4'h1; S2MID = 8'h11; S2END = 8'h12; S4END = 16'h1111;
    #1;
`ifdef S_TERM_REG_EN
    check("reg0_n2", 32'(N2BEG), 32'h3C);
    check("reg0_n4", 32'(N4BEG), 32'hBEEF);
`else
    check("reg0_n2", 32'(N2BEG), 32'h11);
    check("reg0_n4", 32'(N4BEG), 32'h1111);
`endif
    tick();
    S1END = 4'h2; S2MID = 8'h22; S2END = 8'h23; S4END = 16'h2222;
    #1;
`ifdef S_TERM_REG_EN
    check("reg1_n1", 32'(N1BEG), 32'h1);
    check("reg1_n2", 32'(N2BEG), 32'h11);
    check("reg1_n2b", 32'(N2BEGb), 32'h12);
    check("reg1_n4", 32'(N4BEG), 32'h1111);
`else
    check("reg1_n1", 32'(N1BEG), 32'h2);
    check("reg1_n2", 32'(N2BEG), 32'h22);
    check("reg1_n2b", 32'(N2BEGb), 32'h23);
    check("reg1_n4", 32'(N4BEG), 32'h2222);
`endif

    // All ZERO
    load(9'h0AA);
    check("zero_n1", 32'(N1BEG), 32'h0);
    check("zero_n2", 32'(N2BEG), 32'h0);
    check("zero_n2b", 32'(N2BEGb), 32'h0);
    check("zero_n4", 32'(N4BEG), 32'h0);
    check("zero_co", 32'(Co), 32'h0);

    // All ONE
    load(9'h0FF);
    check("one_n1", 32'(N1BEG), 32'hF);
    check("one_n2", 32'(N2BEG), 32'hFF);
    check("one_n2b", 32'(N2BEGb), 32'hFF);
    check("one_n4", 32'(N4BEG), 32'hFFFF);

    // Held strobe: only the first cycle's data (PASS, Co=1) is loaded
    FrameStrobe = '0;
    tick();
    FrameStrobe = 20'd1;
    FrameData = 32'h100; tick();
    FrameData = 32'h0AA; tick();
    FrameData = 32'h0FF; tick();
    FrameData = 32'h155; tick();
    FrameData = 32'h0AA; tick();
    S1END = 4'h7; S4END = 16'h5A5A;
    #1;
    check("hold_co", 32'(Co), 32'h1);
    check("hold_n1", 32'(N1BEG), 32'h7);
    check("hold_n4", 32'(N4BEG), 32'h5A5A);

    // Reset mid-strobe while in REG mode
    load(9'h155);
    FrameData = 32'h1FF;
    FrameStrobe = 20'd1;
    #1;
    resetn = 1'b0;
    S1END = 4'h9; S2MID = 8'h99;
    #1;
    check("mrst_co", 32'(Co), 32'h0);
    check("mrst_n1", 32'(N1BEG), 32'h9);
    check("mrst_n2", 32'(N2BEG), 32'h99);
    tick();
    resetn = 1'b1;
    tick();
    S2MID = 8'h44;
    #1;
    check("post_co", 32'(Co), 32'h0);
    check("post_n2", 32'(N2BEG), 32'h44);
    tick();
    check("post2_co", 32'(Co), 32'h0);
    FrameStrobe = '0;
    tick();
    FrameStrobe = 20'd1;
    tick();
    check("reload_co", 32'(Co), 32'h1);
    check("reload_n1", 32'(N1BEG), 32'hF);
    FrameStrobe = '0;

    // Frame passthrough
    for (int i = 0; i < 8; i++) begin
      FrameData   = $urandom;
      FrameStrobe = 20'($urandom);
      #1;
      check("fdata_o", FrameData_O, FrameData);
      check("fstrobe_o", 32'(FrameStrobe_O), 32'(FrameStrobe));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
